muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//  Execute-stage controller for the RV32M datapath. Accepts one M-type op from E and
//  launches the shared iterative multiplier or divider. Holds the pipeline stall until
//  the result is back, then presents one resp beat. Resolves divide-by-zero/overflow locally.
// PARAMETERS
//  XLEN            32  operand/result width
//  WATCHDOG_CYCLES 64  max cycles in MUL_BUSY/DIV_BUSY/DRAIN before abort
// PORTS
//  clk           in   1     clock
//  rst           in   1     reset, asynchronous, active-low
//  req_valid     in   1     M-type op valid in E; held stable while stall=1
//  req_funct3    in   3     MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU (RV32M funct3)
//  req_a, req_b  in   XLEN  operands (rs1, rs2)
//  flush         in   1     squash E-stage op
//  stall         out  1     hold F/D/E
//  resp_valid    out  1     1-cycle result strobe
//  resp_result   out  XLEN  result, valid when resp_valid=1
//  unit_a,unit_b out  XLEN  registered operands to both units, stable while busy
//  mul_start     out  1     1-cycle launch pulse
//  mul_mode      out  2     00 s*s, 01 s*u, 10 u*u
//  mul_done      in   1     multiplier finished (1 cycle)
//  mul_product   in   2*XLEN full product
//  div_start     out  1     1-cycle launch pulse
//  div_signed    out  1     signed divide
//  div_done      in   1     divider finished (1 cycle)
//  div_quot,div_rem in XLEN divider results
//  timeout_err   out  1     sticky watchdog flag
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; all outputs, operand regs, counter and cache clear to 0.
//  States: IDLE, MUL_BUSY, DIV_BUSY, DONE, DRAIN.
//  IDLE, req_valid & !flush:
//   - div special case: b==0 (quot=all-1s, rem=a) or signed a=0x80000000,b=-1 (quot=a, rem=0).
//     Result is registered; next state DONE; no unit start; latency 1.
//   - otherwise latch a/b/funct3, pulse mul_start or div_start, go to MUL_BUSY or DIV_BUSY.
//  MUL_BUSY/DIV_BUSY: on done, register result and go to DONE.
//   - MUL takes product[31:0]; MULH* take product[63:32].
//   - DIV*/REM* take quot/rem.
//   - done=0 keeps state.
//  DONE: resp_valid=1 for exactly one cycle; stall=0; next state IDLE.
//  stall = (IDLE & req_valid & !flush) | MUL_BUSY | DIV_BUSY | (DRAIN & req_valid).
//  flush in *_BUSY: go to DRAIN. DRAIN waits for the matching done, discards it, goes to IDLE.
//  flush in DONE: resp_valid suppressed; go to IDLE.
//  done and flush in the same cycle: result discarded; go to IDLE.
//  A done in IDLE/DONE, or from the non-launched unit, is ignored.
//  Watchdog counter clears on each launch and counts in BUSY/DRAIN states.
//   - At WATCHDOG_CYCLES: set timeout_err (sticky until reset), force IDLE, no resp_valid.
// CONFIGURATION
//  MULDIV_REUSE_EN defined: muldiv_result_cache keeps the last mul product (a, b, mode)
//  and the last div quot/rem pair (a, b, signed).
//   - A matching request goes IDLE->DONE in 1 cycle with no unit start.
//   - Cache is written on every non-flushed done; cleared only by reset.
//  Not defined: every non-special request launches a unit; no cache logic.
// STRUCTURE
//  muldiv_pkg: m_op_e (funct3 enum), seq_state_e, mul_mode_e, MUL_SS/MUL_SU/MUL_UU, XLEN.
//  Sub-module muldiv_result_cache (compiled only under MULDIV_REUSE_EN).
//  Special-case detect and result mux are inline.
// TESTING
//  1. MUL a=7, b=0xFFFFFFFD.
//     -> mul_start 1 cycle with mode 00; stall=1 until mul_done.
//     -> next cycle resp_valid=1, resp_result=0xFFFFFFEB.
//  2. Local divide cases, each with no div_start and resp at cycle 2:
//     DIV 0x80000000/0xFFFFFFFF -> 0x80000000; DIVU 9/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
//  3. flush during MUL_BUSY -> DRAIN; later mul_done produces no resp_valid; IDLE.
//     A new req launches after that.
//  4. rst=0 mid DIV_BUSY -> stall, resp_valid, mul_start, div_start all 0 immediately.
//     After release, state is IDLE.
//  5. mul_done held 0 -> timeout_err=1 after 64 cycles; stall drops; flag persists.
//  6. MULH 0x80000000*2, then MUL with the same operands:
//     -> 0xFFFFFFFF, then 0x00000000.
//     Second op issues no mul_start with MULDIV_REUSE_EN defined; one mul_start without it.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the RV32M execute-stage mul/div sequencer.
package muldiv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } m_op_e;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MUL_BUSY = 3'd1,
    DIV_BUSY = 3'd2,
    DONE     = 3'd3,
    DRAIN    = 3'd4
  } seq_state_e;

  typedef enum logic [1:0] {
    MUL_SS = 2'b00,
    MUL_SU = 2'b01,
    MUL_UU = 2'b10
  } mul_mode_e;

  // MUL and MULH both want a signed*signed product; only the half taken differs.
  function automatic mul_mode_e mul_mode_of(input m_op_e op);
    case (op)
      OP_MULHSU: return MUL_SU;
      OP_MULHU:  return MUL_UU;
      default:   return MUL_SS;
    endcase
  endfunction

  function automatic logic op_is_div(input m_op_e op);
    return op[2];
  endfunction

  function automatic logic op_is_rem(input m_op_e op);
    return op[2] & op[1];
  endfunction

  function automatic logic op_div_signed(input m_op_e op);
    return op[2] & ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_result_cache.sv
// Remembers the last multiplier product and the last divider quot/rem pair so an
// identical follow-up request (e.g. MULH then MUL, DIV then REM) skips the unit.
// Only instantiated when MULDIV_REUSE_EN is defined.
module muldiv_result_cache #(
  parameter int XLEN = muldiv_pkg::XLEN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  muldiv_pkg::m_op_e    lookup_op,
  input  logic [XLEN-1:0]      lookup_a,
  input  logic [XLEN-1:0]      lookup_b,
  output logic                 hit,
  output logic [XLEN-1:0]      hit_result,
  input  logic                 mul_wr,
  input  logic                 div_wr,
  input  muldiv_pkg::m_op_e    wr_op,
  input  logic [XLEN-1:0]      wr_a,
  input  logic [XLEN-1:0]      wr_b,
  input  logic [2*XLEN-1:0]    wr_product,
  input  logic [XLEN-1:0]      wr_quot,
  input  logic [XLEN-1:0]      wr_rem
);
  import muldiv_pkg::*;

  logic              mul_vld_q, mul_vld_d;
  logic [XLEN-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  mul_mode_e         mul_mode_q, mul_mode_d;
  logic [2*XLEN-1:0] mul_prod_q, mul_prod_d;
  logic              div_vld_q, div_vld_d;
  logic [XLEN-1:0]   div_a_q, div_a_d, div_b_q, div_b_d;
  logic              div_sgn_q, div_sgn_d;
  logic [XLEN-1:0]   div_quot_q, div_quot_d, div_rem_q, div_rem_d;

  // Capture a completed unit result together with the key that produced it.
  always_comb begin
    mul_vld_d  = mul_vld_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    mul_mode_d = mul_mode_q;
    mul_prod_d = mul_prod_q;
    div_vld_d  = div_vld_q;
    div_a_d    = div_a_q;
    div_b_d    = div_b_q;
    div_sgn_d  = div_sgn_q;
    div_quot_d = div_quot_q;
    div_rem_d  = div_rem_q;
    if (mul_wr) begin
      mul_vld_d  = 1'b1;
      mul_a_d    = wr_a;
      mul_b_d    = wr_b;
      mul_mode_d = mul_mode_of(wr_op);
      mul_prod_d = wr_product;
    end
    if (div_wr) begin
      div_vld_d  = 1'b1;
      div_a_d    = wr_a;
      div_b_d    = wr_b;
      div_sgn_d  = op_div_signed(wr_op);
      div_quot_d = wr_quot;
      div_rem_d  = wr_rem;
    end
  end

  // Cache storage; only reset ever invalidates it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_vld_q  <= 1'b0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      mul_mode_q <= MUL_SS;
      mul_prod_q <= '0;
      div_vld_q  <= 1'b0;
      div_a_q    <= '0;
      div_b_q    <= '0;
      div_sgn_q  <= 1'b0;
      div_quot_q <= '0;
      div_rem_q  <= '0;
    end else begin
      mul_vld_q  <= mul_vld_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      mul_mode_q <= mul_mode_d;
      mul_prod_q <= mul_prod_d;
      div_vld_q  <= div_vld_d;
      div_a_q    <= div_a_d;
      div_b_q    <= div_b_d;
      div_sgn_q  <= div_sgn_d;
      div_quot_q <= div_quot_d;
      div_rem_q  <= div_rem_d;
    end
  end

  // Key match against the incoming request and pick the half/field it asks for.
  always_comb begin
    hit        = 1'b0;
    hit_result = '0;
    if (op_is_div(lookup_op)) begin
      if (div_vld_q && lookup_a == div_a_q && lookup_b == div_b_q &&
          op_div_signed(lookup_op) == div_sgn_q) begin
        hit        = 1'b1;
        hit_result = op_is_rem(lookup_op) ? div_rem_q : div_quot_q;
      end
    end else if (mul_vld_q && lookup_a == mul_a_q && lookup_b == mul_b_q &&
                 mul_mode_of(lookup_op) == mul_mode_q) begin
      hit        = 1'b1;
      hit_result = (lookup_op == OP_MUL) ? mul_prod_q[XLEN-1:0] : mul_prod_q[2*XLEN-1:XLEN];
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Execute-stage controller for the RV32M mul/div units: launches one op, stalls the
// pipe until the unit answers, and emits a single response beat. Divide-by-zero and
// signed overflow are answered locally. Optional result reuse: MULDIV_REUSE_EN.
module muldiv_sequencer #(
  parameter int XLEN            = muldiv_pkg::XLEN,
  parameter int WATCHDOG_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_a,
  input  logic [XLEN-1:0]   req_b,
  input  logic              flush,
  output logic              stall,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_result,
  output logic [XLEN-1:0]   unit_a,
  output logic [XLEN-1:0]   unit_b,
  output logic              mul_start,
  output logic [1:0]        mul_mode,
  input  logic              mul_done,
  input  logic [2*XLEN-1:0] mul_product,
  output logic              div_start,
  output logic              div_signed,
  input  logic              div_done,
  input  logic [XLEN-1:0]   div_quot,
  input  logic [XLEN-1:0]   div_rem,
  output logic              timeout_err
);
  import muldiv_pkg::*;

  localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);

  seq_state_e        state_q, state_d;
  m_op_e             op_q, op_d;
  logic [XLEN-1:0]   unit_a_q, unit_a_d, unit_b_q, unit_b_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic              timeout_q, timeout_d;
  logic              mul_start_q, mul_start_d, div_start_q, div_start_d;

  m_op_e             req_op;
  logic              accept, special, wd_expired, launched_done;
  logic [XLEN-1:0]   special_result, unit_result;
  logic              cache_hit;
  logic [XLEN-1:0]   cache_result;

`ifdef MULDIV_REUSE_EN
  muldiv_result_cache #(.XLEN(XLEN)) u_cache (
    .clk        (clk),
    .rst        (rst),
    .lookup_op  (req_op),
    .lookup_a   (req_a),
    .lookup_b   (req_b),
    .hit        (cache_hit),
    .hit_result (cache_result),
    .mul_wr     ((state_q == MUL_BUSY) && mul_done && !flush),
    .div_wr     ((state_q == DIV_BUSY) && div_done && !flush),
    .wr_op      (op_q),
    .wr_a       (unit_a_q),
    .wr_b       (unit_b_q),
    .wr_product (mul_product),
    .wr_quot    (div_quot),
    .wr_rem     (div_rem)
  );
`else
  assign cache_hit    = 1'b0;
  assign cache_result = '0;
`endif

  // Decode the request and resolve divide-by-zero / signed overflow without the divider.
  always_comb begin
    req_op         = m_op_e'(req_funct3);
    accept         = (state_q == IDLE) && req_valid && !flush;
    special        = 1'b0;
    special_result = '0;
    if (op_is_div(req_op)) begin
      if (req_b == '0) begin
        special        = 1'b1;
        special_result = op_is_rem(req_op) ? req_a : '1;
      end else if (op_div_signed(req_op) && req_a == {1'b1, {(XLEN-1){1'b0}}} && req_b == '1) begin
        special        = 1'b1;
        special_result = op_is_rem(req_op) ? '0 : req_a;
      end
    end
    launched_done = op_is_div(op_q) ? div_done : mul_done;
    if (op_is_div(op_q))
      unit_result = op_is_rem(op_q) ? div_rem : div_quot;
    else
      unit_result = (op_q == OP_MUL) ? mul_product[XLEN-1:0] : mul_product[2*XLEN-1:XLEN];
    wd_expired = (wd_cnt_q >= WD_W'(WATCHDOG_CYCLES - 1));
  end

  // Next-state, launch and watchdog logic.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    unit_a_d    = unit_a_q;
    unit_b_d    = unit_b_q;
    result_d    = result_q;
    wd_cnt_d    = wd_cnt_q;
    timeout_d   = timeout_q;
    mul_start_d = 1'b0;
    div_start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (special) begin
            result_d = special_result;
            state_d  = DONE;
          end else if (cache_hit) begin
            result_d = cache_result;
            state_d  = DONE;
          end else begin
            op_d     = req_op;
            unit_a_d = req_a;
            unit_b_d = req_b;
            wd_cnt_d = '0;
            if (op_is_div(req_op)) begin
              div_start_d = 1'b1;
              state_d     = DIV_BUSY;
            end else begin
              mul_start_d = 1'b1;
              state_d     = MUL_BUSY;
            end
          end
        end
      end
      MUL_BUSY, DIV_BUSY: begin
        if (launched_done) begin
          state_d = flush ? IDLE : DONE;
          if (!flush) result_d = unit_result;
        end else if (wd_expired) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
          if (flush) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (launched_done) begin
          state_d = IDLE;
        end else if (wd_expired) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, operand, result and watchdog registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      op_q        <= OP_MUL;
      unit_a_q    <= '0;
      unit_b_q    <= '0;
      result_q    <= '0;
      wd_cnt_q    <= '0;
      timeout_q   <= 1'b0;
      mul_start_q <= 1'b0;
      div_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      unit_a_q    <= unit_a_d;
      unit_b_q    <= unit_b_d;
      result_q    <= result_d;
      wd_cnt_q    <= wd_cnt_d;
      timeout_q   <= timeout_d;
      mul_start_q <= mul_start_d;
      div_start_q <= div_start_d;
    end
  end

  // Stall is forced low while reset is held so a pending request cannot freeze the pipe.
  always_comb begin
    stall = rst && (((state_q == IDLE) && req_valid && !flush) ||
                    (state_q == MUL_BUSY) || (state_q == DIV_BUSY) ||
                    ((state_q == DRAIN) && req_valid));
    resp_valid = (state_q == DONE) && !flush;
  end

  assign resp_result = result_q;
  assign unit_a      = unit_a_q;
  assign unit_b      = unit_b_q;
  assign mul_start   = mul_start_q;
  assign div_start   = div_start_q;
  assign mul_mode    = mul_mode_of(op_q);
  assign div_signed  = op_div_signed(op_q);
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer; the bench plays the role of both arithmetic units.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [2:0]  req_funct3;
  logic [31:0] req_a, req_b;
  logic        flush;
  logic        stall, resp_valid;
  logic [31:0] resp_result, unit_a, unit_b;
  logic        mul_start, div_start, div_signed, timeout_err;
  logic [1:0]  mul_mode;
  logic        mul_done, div_done;
  logic [63:0] mul_product;
  logic [31:0] div_quot, div_rem;

  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] expQ[$];

  muldiv_sequencer dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_funct3(req_funct3),
    .req_a(req_a), .req_b(req_b), .flush(flush), .stall(stall),
    .resp_valid(resp_valid), .resp_result(resp_result), .unit_a(unit_a), .unit_b(unit_b),
    .mul_start(mul_start), .mul_mode(mul_mode), .mul_done(mul_done), .mul_product(mul_product),
    .div_start(div_start), .div_signed(div_signed), .div_done(div_done),
    .div_quot(div_quot), .div_rem(div_rem), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Reference multiplier: extend operands per mode, keep the low 64 bits of the product.
  function automatic logic [63:0] mulModel(input logic [31:0] a, input logic [31:0] b, input logic [1:0] mode);
    logic [63:0] ea, eb;
    ea = (mode != 2'b10 && a[31]) ? {32'hFFFFFFFF, a} : {32'h0, a};
    eb = (mode == 2'b00 && b[31]) ? {32'hFFFFFFFF, b} : {32'h0, b};
    return ea * eb;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] f, input logic [31:0] a,
                               input logic [31:0] b, input logic fl);
    req_valid  = v;
    req_funct3 = f;
    req_a      = a;
    req_b      = b;
    flush      = fl;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Response beat must be present now and carry the oldest scoreboard entry.
  task automatic checkResp(input string tag);
    logic [31:0] exp;
    checkOutput({tag, "_valid"}, resp_valid, 1);
    if (expQ.size() == 0) begin
      compared++;
      mismatched++;
      $error("[TB] FAIL %s_result: observed %0h expected no response", tag, resp_result);
    end else begin
      exp = expQ.pop_front();
      checkOutput({tag, "_result"}, resp_result, exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(0, 3'b000, 0, 0, 0);
    mul_done = 0; mul_product = '0; div_done = 0; div_quot = '0; div_rem = '0;

    // Reset state
    #12;
    checkOutput("rst_stall", stall, 0);
    checkOutput("rst_resp_valid", resp_valid, 0);
    checkOutput("rst_mul_start", mul_start, 0);
    checkOutput("rst_result", resp_result, 0);
    checkOutput("rst_timeout", timeout_err, 0);
    tick();
    rst = 1'b1;
    tick();

    // 1: MUL 7 * -3
    $display("[TB] test 1: MUL");
    applyStimulus(1, OP_MUL, 32'd7, 32'hFFFFFFFD, 0);
    expQ.push_back(32'hFFFFFFEB);
    #1 checkOutput("t1_stall_req", stall, 1);
    tick();
    applyStimulus(0, OP_MUL, 0, 0, 0);
    #1;
    checkOutput("t1_mul_start", mul_start, 1);
    checkOutput("t1_mul_mode", mul_mode, 2'b00);
    checkOutput("t1_unit_b", unit_b, 32'hFFFFFFFD);
    checkOutput("t1_stall_busy", stall, 1);
    tick();
    checkOutput("t1_mul_start_pulse", mul_start, 0);
    checkOutput("t1_stall_wait", stall, 1);
    mul_done = 1; mul_product = mulModel(32'd7, 32'hFFFFFFFD, 2'b00);
    tick();
    mul_done = 0;
    #1;
    checkResp("t1");
    checkOutput("t1_stall_done", stall, 0);
    tick();
    checkOutput("t1_resp_one_cycle", resp_valid, 0);

    // 2: locally resolved divides
    $display("[TB] test 2: local divide");
    applyStimulus(1, OP_DIV, 32'h80000000, 32'hFFFFFFFF, 0);
    expQ.push_back(32'h80000000);
    tick();
    applyStimulus(0, OP_DIV, 0, 0, 0);
    #1;
    checkOutput("t2a_no_div_start", div_start, 0);
    checkResp("t2a");
    tick();
    applyStimulus(1, OP_DIVU, 32'd9, 32'd0, 0);
    expQ.push_back(32'hFFFFFFFF);
    tick();
    applyStimulus(0, OP_DIV, 0, 0, 0);
    #1;
    checkOutput("t2b_no_div_start", div_start, 0);
    checkResp("t2b");
    tick();
    applyStimulus(1, OP_REM, 32'd5, 32'd0, 0);
    expQ.push_back(32'd5);
    tick();
    applyStimulus(0, OP_DIV, 0, 0, 0);
    #1;
    checkOutput("t2c_no_div_start", div_start, 0);
    checkResp("t2c");
    tick();

    // 2d: real signed divide, stray mul_done ignored
    applyStimulus(1, OP_DIV, 32'hFFFFFFF9, 32'd2, 0);
    expQ.push_back(32'hFFFFFFFD);
    tick();
    applyStimulus(0, OP_DIV, 0, 0, 0);
    #1;
    checkOutput("t2d_div_start", div_start, 1);
    checkOutput("t2d_div_signed", div_signed, 1);
    mul_done = 1; mul_product = 64'h1234;
    tick();
    mul_done = 0;
    #1;
    checkOutput("t2d_stray_done_stall", stall, 1);
    checkOutput("t2d_stray_done_resp", resp_valid, 0);
    div_done = 1;
    div_quot = 32'($signed(32'hFFFFFFF9) / $signed(32'd2));
    div_rem  = 32'($signed(32'hFFFFFFF9) % $signed(32'd2));
    tick();
    div_done = 0;
    #1 checkResp("t2d");
    tick();

    // 3: flush during MUL_BUSY, drain, relaunch
    $display("[TB] test 3: flush and drain");
    applyStimulus(1, OP_MUL, 32'd3, 32'd4, 0);
    tick();
    applyStimulus(0, OP_MUL, 0, 0, 1);
    tick();
    applyStimulus(0, OP_MUL, 0, 0, 0);
    #1 checkOutput("t3_drain_no_stall", stall, 0);
    applyStimulus(1, OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    #1 checkOutput("t3_drain_stall_req", stall, 1);
    mul_done = 1; mul_product = 64'd12;
    tick();
    mul_done = 0;
    #1;
    checkOutput("t3_drained_no_resp", resp_valid, 0);
    checkOutput("t3_idle_stall_req", stall, 1);
    expQ.push_back(32'hFFFFFFFE);
    tick();
    applyStimulus(0, OP_MUL, 0, 0, 0);
    #1;
    checkOutput("t3_relaunch", mul_start, 1);
    checkOutput("t3_mode_uu", mul_mode, 2'b10);
    mul_done = 1; mul_product = mulModel(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10);
    tick();
    mul_done = 0;
    #1 checkResp("t3");
    tick();

    // 4: reset mid DIV_BUSY
    $display("[TB] test 4: reset while busy");
    applyStimulus(1, OP_DIVU, 32'd100, 32'd7, 0);
    tick();
    #1 checkOutput("t4_div_start", div_start, 1);
    rst = 1'b0;
    #1;
    checkOutput("t4_rst_stall", stall, 0);
    checkOutput("t4_rst_resp", resp_valid, 0);
    checkOutput("t4_rst_mul_start", mul_start, 0);
    checkOutput("t4_rst_div_start", div_start, 0);
    checkOutput("t4_rst_unit_a", unit_a, 0);
    applyStimulus(0, OP_MUL, 0, 0, 0);
    tick();
    rst = 1'b1;
    tick();
    applyStimulus(1, OP_REMU, 32'd7, 32'd0, 0);
    expQ.push_back(32'd7);
    tick();
    applyStimulus(0, OP_MUL, 0, 0, 0);
    #1 checkResp("t4_idle_after_rst");
    tick();
    applyStimulus(1, OP_DIVU, 32'd9, 32'd0, 0);
    tick();
    applyStimulus(0, OP_MUL, 0, 0, 1);
    #1 checkOutput("t4_flush_done_resp", resp_valid, 0);
    tick();
    applyStimulus(0, OP_MUL, 0, 0, 0);
    #1 checkOutput("t4_after_flush_resp", resp_valid, 0);
    checkOutput("t4_timeout_clear", timeout_err, 0);

    // 5: watchdog
    $display("[TB] test 5: watchdog");
    applyStimulus(1, OP_MUL, 32'd2, 32'd3, 0);
    tick();
    applyStimulus(0, OP_MUL, 0, 0, 0);
    for (int i = 0; i < 63; i++) tick();
    checkOutput("t5_not_yet", timeout_err, 0);
    checkOutput("t5_still_stall", stall, 1);
    tick();
    checkOutput("t5_timeout", timeout_err, 1);
    checkOutput("t5_stall_drop", stall, 0);
    checkOutput("t5_no_resp", resp_valid, 0);
    tick();
    tick();

    // 6: MULH then MUL on the same operands
    $display("[TB] test 6: result reuse");
    applyStimulus(1, OP_MULH, 32'h80000000, 32'd2, 0);
    expQ.push_back(32'hFFFFFFFF);
    tick();
    applyStimulus(0, OP_MUL, 0, 0, 0);
    #1 checkOutput("t6a_mul_start", mul_start, 1);
    mul_done = 1; mul_product = mulModel(32'h80000000, 32'd2, 2'b00);
    tick();
    mul_done = 0;
    #1 checkResp("t6a");
    tick();
    applyStimulus(1, OP_MUL, 32'h80000000, 32'd2, 0);
    expQ.push_back(32'h00000000);
    tick();
    applyStimulus(0, OP_MUL, 0, 0, 0);
    #1;
`ifdef MULDIV_REUSE_EN
    checkOutput("t6b_reuse_no_start", mul_start, 0);
    checkResp("t6b");
`else
    checkOutput("t6b_mul_start", mul_start, 1);
    mul_done = 1; mul_product = mulModel(32'h80000000, 32'd2, 2'b00);
    tick();
    mul_done = 0;
    #1 checkResp("t6b");
`endif
    tick();
    checkOutput("t6_timeout_sticky", timeout_err, 1);
    checkOutput("sb_empty", expQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
